// File: rtl/rr_select_arbiter_4.sv
// Four-source round-robin arbiter driving the select lines of a downstream 4:1 mux.
// The grant is registered and one-hot, with a hold limit that applies while other sources are waiting.
module rr_select_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       S0,
  output logic       S1,
  output logic       VALID
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned IDXW = 2;
  localparam int unsigned CNTW = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNTW-1:0] HOLD_MAX = CNTW'(MAX_HOLD);

  // First set request bit at or after start, wrapping 3 -> 0.
  function automatic logic [IDXW-1:0] first_req(input logic [NSRC-1:0] req,
                                                input logic [IDXW-1:0] start);
    logic [IDXW-1:0] idx;
    logic            found;
    first_req = start;
    found     = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      idx = start + IDXW'(i);
      if (!found && req[idx]) begin
        first_req = idx;
        found     = 1'b1;
      end
    end
  endfunction

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] own_q, own_d;
  logic [IDXW-1:0] pri_q, pri_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NSRC-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] sel_q, sel_d;
  logic            valid_q, valid_d;

  logic            grant_new;
  logic [IDXW-1:0] grant_idx;
  logic [NSRC-1:0] others;

  // State and output registers; EN low freezes everything except reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      pri_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (EN) begin
      state_q <= state_d;
      own_q   <= own_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and next-output decision.
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    pri_d     = pri_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    grant_new = 1'b0;
    grant_idx = own_q;
    others    = REQ & ~(NSRC'(1) << own_q);

    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          grant_new = 1'b1;
          grant_idx = first_req(REQ, pri_q);
        end
      end
      ST_GRANT: begin
        if (!REQ[own_q]) begin
          if (|others) begin
            grant_new = 1'b1;
            grant_idx = first_req(others, own_q + IDXW'(1));
          end else begin
            // Select lines keep their last value so the mux input does not move.
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else if (cnt_q < HOLD_MAX) begin
          cnt_d = cnt_q + CNTW'(1);
        end else if (|others) begin
          grant_new = 1'b1;
          grant_idx = first_req(others, own_q + IDXW'(1));
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant_new) begin
      state_d = ST_GRANT;
      own_d   = grant_idx;
      pri_d   = grant_idx + IDXW'(1);
      cnt_d   = CNTW'(1);
      gnt_d   = NSRC'(1) << grant_idx;
      sel_d   = grant_idx;
      valid_d = 1'b1;
    end
  end

  assign GNT   = gnt_q;
  assign S0    = sel_q[0];
  assign S1    = sel_q[1];
  assign VALID = valid_q;

endmodule

// File: tb/tb_rr_select_arbiter_4.sv
// Scoreboard bench for rr_select_arbiter_4: directed scenarios plus randomized traffic,
// checked against a behavioural round-robin model.
module tb_rr_select_arbiter_4;

  localparam int MAXH = 4;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       S0;
  logic       S1;
  logic       VALID;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state
  bit m_busy = 0;
  int m_own  = 0;
  int m_pri  = 0;
  int m_hold = 0;
  int m_sel  = 0;

  rr_select_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .REQ  (REQ),
    .GNT  (GNT),
    .S0   (S0),
    .S1   (S1),
    .VALID(VALID)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int pick(logic [3:0] r, int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_grant(int j);
    m_busy = 1;
    m_own  = j;
    m_pri  = (j + 1) % 4;
    m_hold = 1;
    m_sel  = j;
  endtask

  task automatic model_edge(bit rst, bit en, logic [3:0] r);
    logic [3:0] rest;
    if (rst) begin
      m_busy = 0; m_own = 0; m_pri = 0; m_hold = 0; m_sel = 0;
    end else if (en) begin
      rest = r;
      rest[m_own] = 1'b0;
      if (!m_busy) begin
        if (r != 4'b0) m_grant(pick(r, m_pri));
      end else if (!r[m_own]) begin
        if (r != 4'b0) m_grant(pick(r, m_own + 1));
        else m_busy = 0;
      end else if (m_hold < MAXH) begin
        m_hold = m_hold + 1;
      end else if (rest != 4'b0) begin
        m_grant(pick(rest, m_own + 1));
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = m_busy ? (4'b0001 << m_own) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.valid = m_busy;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue the expected response, then return just after the edge.
  task automatic step(bit rst, bit en, logic [3:0] r);
    @(negedge CLK);
    RST = rst;
    EN  = en;
    REQ = r;
    model_edge(rst, en, r);
    sb_q.push_back(model_out());
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(string name, logic [3:0] g, logic [1:0] s, logic v);
    checks++;
    if (GNT !== g || {S1, S0} !== s || VALID !== v) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
               name, GNT, {S1, S0}, VALID, g, s, v);
    end
  endtask

  // Monitor: compare every registered output against the queued expectation.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        got = '{gnt: GNT, sel: {S1, S0}, valid: VALID};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                   $time, got.gnt, got.sel, got.valid, e.gnt, e.sel, e.valid);
        end
        checks++;
        if ((VALID === 1'b1 && !$onehot(GNT)) || (VALID !== 1'b1 && GNT !== 4'b0000)) begin
          errors++;
          $display("FAIL onehot @%0t: gnt=%b valid=%b", $time, GNT, VALID);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [3:0] g;
    bit         en;
    bit         rst;
    RST = 1'b1;
    EN  = 1'b1;
    REQ = 4'b1111;

    // Reset with everything requesting, then full contention rotation
    step(1, 1, 4'b1111);
    chk("reset_edge1", 4'b0000, 2'b00, 1'b0);
    step(1, 1, 4'b1111);
    chk("reset_edge2", 4'b0000, 2'b00, 1'b0);
    for (int i = 0; i <= 16; i++) begin
      step(0, 1, 4'b1111);
      g = 4'b0001 << ((i / 4) % 4);
      chk("contention", g, 2'((i / 4) % 4), 1'b1);
    end

    // Enable freeze in the middle of the A grant
    step(1, 1, 4'b1111);
    step(0, 1, 4'b1111);
    step(0, 1, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b1111);
      chk("freeze", 4'b0001, 2'b00, 1'b1);
    end
    step(0, 1, 4'b1111);
    chk("freeze_after1", 4'b0001, 2'b00, 1'b1);
    step(0, 1, 4'b1111);
    chk("freeze_after2", 4'b0001, 2'b00, 1'b1);
    step(0, 1, 4'b1111);
    chk("freeze_rotate", 4'b0010, 2'b01, 1'b1);

    // Reset while C owns the mux
    step(1, 1, 4'b1111);
    for (int i = 0; i < 9; i++) step(0, 1, 4'b1111);
    chk("pre_midreset", 4'b0100, 2'b10, 1'b1);
    step(1, 1, 4'b1111);
    chk("midreset", 4'b0000, 2'b00, 1'b0);
    step(0, 1, 4'b1111);
    chk("midreset_release", 4'b0001, 2'b00, 1'b1);

    // Single source never rotates
    step(1, 1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 4'b0100);
      chk("single", 4'b0100, 2'b10, 1'b1);
    end

    // Early release, wrap, and idle with held select
    step(1, 1, 4'b0000);
    step(0, 1, 4'b0010);
    chk("early_b", 4'b0010, 2'b01, 1'b1);
    step(0, 1, 4'b1001);
    chk("early_d", 4'b1000, 2'b11, 1'b1);
    step(0, 1, 4'b0001);
    chk("wrap_a", 4'b0001, 2'b00, 1'b1);
    step(0, 1, 4'b1000);
    chk("handoff_d", 4'b1000, 2'b11, 1'b1);
    step(0, 1, 4'b0000);
    chk("idle_hold_sel", 4'b0000, 2'b11, 1'b0);
    step(0, 1, 4'b0010);
    chk("idle_pri_after_d", 4'b0010, 2'b01, 1'b1);

    // Randomized traffic with occasional enable drops and resets
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 150) == 0);
      step(rst, en, r);
    end

    step(0, 1, 4'b0000);
    @(posedge CLK);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
